// File: rtl/fifo_warb_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
// Two-state grant FSM, 4-bit burst counter, 16-bit saturating statistics.
package fifo_warb_pkg;

  typedef enum logic {
    WARB_IDLE  = 1'b0,
    WARB_GRANT = 1'b1
  } warb_state_t;

  localparam int WARB_STAT_W = 16;
  localparam int WARB_BEAT_W = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, zero latency.
// Returns the first set bit of req searching upward from last+1, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter onto the CDC FIFO write port; FIFO_WARB_STATS_EN adds counters.
// Grant one cycle after valid; write strobe/data combinational; req_ready tracks !fifo_full in the same cycle.
module fifo_write_arbiter
  import fifo_warb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 10,
  parameter  int BURST_MAX = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      write_clk,
  input  logic                      write_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_write_enable,
  output logic [DATA_W-1:0]         fifo_write_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
`ifdef FIFO_WARB_STATS_EN
  ,
  output logic [NUM_REQ*WARB_STAT_W-1:0] stat_beats,
  output logic [WARB_STAT_W-1:0]         stat_stall
`endif
);

  localparam logic [WARB_BEAT_W-1:0] BEAT_LAST = WARB_BEAT_W'(BURST_MAX - 1);

  warb_state_t            state;
  logic [ID_W-1:0]        owner;
  logic [ID_W-1:0]        last;
  logic [WARB_BEAT_W-1:0] beats;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;
  logic                   owner_vld;
  logic [DATA_W-1:0]      owner_dat;
  logic                   beat;

  rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
    .req    (req_valid),
    .last   (last),
    .found  (pick_found),
    .winner (pick_id)
  );

  always_comb begin
    owner_vld = 1'b0;
    owner_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_vld = req_valid[i];
        owner_dat = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy = (state == WARB_GRANT);
  assign beat = busy && owner_vld && !fifo_full;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy && !fifo_full && owner == ID_W'(i)) req_ready[i] = 1'b1;
    end
  end

  assign fifo_write_enable = beat;
  assign fifo_write_data   = beat ? owner_dat : '0;
  assign grant_id          = busy ? owner : '0;

  // Stalled cycles leave beats untouched; a dropped owner valid forfeits the grant even while full.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      state <= WARB_IDLE;
      owner <= '0;
      last  <= ID_W'(NUM_REQ - 1);
      beats <= '0;
    end else begin
      case (state)
        WARB_IDLE: begin
          if (pick_found) begin
            owner <= pick_id;
            last  <= pick_id;
            beats <= '0;
            state <= WARB_GRANT;
          end
        end
        WARB_GRANT: begin
          if (!owner_vld) begin
            state <= WARB_IDLE;
          end else if (beat) begin
            beats <= beats + WARB_BEAT_W'(1);
            if (beats == BEAT_LAST) state <= WARB_IDLE;
          end
        end
        default: state <= WARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_WARB_STATS_EN
  logic [NUM_REQ-1:0][WARB_STAT_W-1:0] beat_cnt;
  logic [WARB_STAT_W-1:0]              stall_cnt;

  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (beat && owner == ID_W'(i) && beat_cnt[i] != '1)
          beat_cnt[i] <= beat_cnt[i] + WARB_STAT_W'(1);
      end
      if (busy && owner_vld && fifo_full && stall_cnt != '1)
        stall_cnt <= stall_cnt + WARB_STAT_W'(1);
    end
  end

  assign stat_beats = beat_cnt;
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random traffic into an 8-deep FIFO model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int BM = 4;

  logic            write_clk = 1'b0;
  logic            write_rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_write_enable;
  logic [DW-1:0]   fifo_write_data;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef FIFO_WARB_STATS_EN
  logic [N*16-1:0] stat_beats;
  logic [15:0]     stat_stall;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [17:0] obs;
  assign obs = {busy, grant_id, fifo_write_enable, fifo_write_data, req_ready};

  always #5 write_clk = ~write_clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .write_clk         (write_clk),
    .write_rst         (write_rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .fifo_full         (fifo_full),
    .fifo_write_enable (fifo_write_enable),
    .fifo_write_data   (fifo_write_data),
    .grant_id          (grant_id),
    .busy              (busy)
`ifdef FIFO_WARB_STATS_EN
    ,
    .stat_beats        (stat_beats),
    .stat_stall        (stat_stall)
`endif
  );

  function automatic logic [17:0] pk(input logic b, input int id, input logic we,
                                     input logic [DW-1:0] d, input logic [N-1:0] rdy);
    pk = {b, 2'(id), we, d, rdy};
  endfunction

  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  task automatic do_reset();
    write_rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    step();
    step();
    write_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    write_rst = 1'b1;
    req_valid = '1;
    req_data  = {$urandom, $urandom};
    fifo_full = 1'b0;
    step();
    step();
    #2;
    exp = pk(1'b0, 0, 1'b0, '0, '0);
    chk_cnt++;
    if (obs !== exp) $display("FAIL reset_hold got=%h exp=%h", obs, exp);
    else pass_cnt++;
    write_rst = 1'b0;
    req_valid = '0;
    step();
    #2;
    chk_cnt++;
    if (obs !== exp) $display("FAIL reset_idle got=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_single_burst();
    logic [17:0] exp;
    do_reset();
    req_data[2*DW +: DW] = 10'h155;
    req_valid = 4'b0100;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) req_valid = '0;
      #2;
      if (c >= 1 && c <= 4) exp = pk(1'b1, 2, 1'b1, 10'h155, 4'b0100);
      else                  exp = pk(1'b0, 0, 1'b0, '0, '0);
      chk_cnt++;
      if (obs !== exp) $display("FAIL single_burst c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_all_valid();
    logic [DW-1:0] d [N];
    logic [17:0]   exp;
    int            own;
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = DW'($urandom_range(0, 1023));
      req_data[i*DW +: DW] = d[i];
    end
    req_valid = '1;
    for (int c = 0; c < 25; c++) begin
      #2;
      own = ((c - 1) / (BM + 1)) % N;
      if (c >= 1 && ((c - 1) % (BM + 1)) < BM)
        exp = pk(1'b1, own, 1'b1, d[own], N'(1 << own));
      else
        exp = pk(1'b0, 0, 1'b0, '0, '0);
      chk_cnt++;
      if (obs !== exp) $display("FAIL all_valid c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    logic [17:0]   exp;
    do_reset();
    d = DW'($urandom_range(0, 1023));
    req_data[1*DW +: DW] = d;
    req_valid = 4'b0010;
    for (int c = 0; c <= 8; c++) begin
      fifo_full = (c >= 2 && c <= 4);
      #2;
      if (c == 0 || c == 8)      exp = pk(1'b0, 0, 1'b0, '0, '0);
      else if (c >= 2 && c <= 4) exp = pk(1'b1, 1, 1'b0, '0, '0);
      else                       exp = pk(1'b1, 1, 1'b1, d, 4'b0010);
      chk_cnt++;
      if (obs !== exp) $display("FAIL stall c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      step();
    end
    req_valid = '0;
    fifo_full = 1'b0;
    #2;
`ifdef FIFO_WARB_STATS_EN
    chk_cnt++;
    if (stat_stall !== 16'd3) $display("FAIL stat_stall got=%0d exp=3", stat_stall);
    else pass_cnt++;
    chk_cnt++;
    if (stat_beats[16 +: 16] !== 16'd4) $display("FAIL stat_beats1 got=%0d exp=4", stat_beats[16 +: 16]);
    else pass_cnt++;
`endif
    step();
  endtask

  task automatic test_drop_valid();
    logic [DW-1:0] d0, d3;
    logic [17:0]   exp;
    do_reset();
    d0 = DW'($urandom_range(0, 1023));
    d3 = DW'($urandom_range(0, 1023));
    req_data[0 +: DW]    = d0;
    req_data[3*DW +: DW] = d3;
    req_valid = 4'b1001;
    for (int c = 0; c <= 5; c++) begin
      if (c == 3) req_valid = 4'b1000;
      #2;
      case (c)
        1, 2:    exp = pk(1'b1, 0, 1'b1, d0, 4'b0001);
        3:       exp = pk(1'b1, 0, 1'b0, '0, 4'b0001);
        5:       exp = pk(1'b1, 3, 1'b1, d3, 4'b1000);
        default: exp = pk(1'b0, 0, 1'b0, '0, '0);
      endcase
      chk_cnt++;
      if (obs !== exp) $display("FAIL drop_valid c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] d0;
    logic [17:0]   exp;
    do_reset();
    d0 = DW'($urandom_range(0, 1023));
    req_data[0 +: DW]    = d0;
    req_data[2*DW +: DW] = DW'($urandom_range(0, 1023));
    req_valid = 4'b0101;
    for (int c = 0; c <= 4; c++) begin
      write_rst = (c == 2);
      #2;
      if (c == 0 || c == 3) exp = pk(1'b0, 0, 1'b0, '0, '0);
      else                  exp = pk(1'b1, 0, 1'b1, d0, 4'b0001);
      chk_cnt++;
      if (obs !== exp) $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      step();
    end
    write_rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_random();
    logic          src_vld [N];
    int            src_seq [N];
    logic [1:0]    id2;
    logic [7:0]    s8;
    logic [N-1:0]  hs, prev_valid, exp_rdy;
    logic          prev_busy;
    int            cnt, cnt_next, model_last, burst, prev_burst, exp_own, w, writes;
    logic          nxt_vld [N];
    int            nxt_seq [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      src_vld[i] = 1'($urandom_range(0, 1));
      src_seq[i] = 0;
    end
    cnt = 0; model_last = N - 1; prev_busy = 1'b0; prev_valid = '0;
    burst = 0; writes = 0;
    for (int c = 0; c < 3000; c++) begin
      fifo_full = (cnt == 8);
      for (int i = 0; i < N; i++) begin
        id2 = 2'(i);
        s8  = 8'(src_seq[i]);
        req_valid[i] = src_vld[i];
        req_data[i*DW +: DW] = {id2, s8};
      end
      #2;
      hs = req_ready & req_valid;

      chk_cnt++;
      if (fifo_write_enable && fifo_full) $display("FAIL rnd_write_full c=%0d we=1 full=1", c);
      else pass_cnt++;

      chk_cnt++;
      if (((hs != '0) !== fifo_write_enable) || $countones(hs) > 1)
        $display("FAIL rnd_handshake c=%0d hs=%b we=%b", c, hs, fifo_write_enable);
      else pass_cnt++;

      w = -1;
      for (int i = 0; i < N; i++) if (hs[i]) w = i;
      chk_cnt++;
      if (w >= 0) begin
        id2 = 2'(w);
        s8  = 8'(src_seq[w]);
        if (fifo_write_data !== {id2, s8})
          $display("FAIL rnd_data c=%0d got=%h exp=%h", c, fifo_write_data, {id2, s8});
        else pass_cnt++;
      end else begin
        if (fifo_write_data !== '0) $display("FAIL rnd_idle_data c=%0d got=%h exp=0", c, fifo_write_data);
        else pass_cnt++;
      end

      exp_rdy = (busy && !fifo_full) ? N'(1 << grant_id) : '0;
      chk_cnt++;
      if (req_ready !== exp_rdy) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
      else pass_cnt++;

      if (!prev_busy) begin
        exp_own = -1;
        for (int k = 1; k <= N; k++)
          if (exp_own < 0 && prev_valid[(model_last + k) % N]) exp_own = (model_last + k) % N;
        chk_cnt++;
        if (exp_own < 0) begin
          if (busy !== 1'b0) $display("FAIL rnd_spurious_grant c=%0d busy=%b exp=0", c, busy);
          else pass_cnt++;
        end else begin
          if (busy !== 1'b1 || grant_id !== 2'(exp_own))
            $display("FAIL rnd_grant c=%0d busy=%b id=%0d exp_id=%0d", c, busy, grant_id, exp_own);
          else pass_cnt++;
          model_last = exp_own;
        end
      end

      if (prev_busy && prev_burst == BM) begin
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL rnd_burst_release c=%0d busy=%b exp=0", c, busy);
        else pass_cnt++;
      end
      if (busy && !prev_busy) burst = 0;
      if (fifo_write_enable) begin
        burst++;
        writes++;
        chk_cnt++;
        if (burst > BM) $display("FAIL rnd_burst_len c=%0d got=%0d max=%0d", c, burst, BM);
        else pass_cnt++;
      end

      for (int i = 0; i < N; i++) begin
        nxt_seq[i] = src_seq[i];
        nxt_vld[i] = src_vld[i];
        if (hs[i]) begin
          nxt_seq[i] = src_seq[i] + 1;
          nxt_vld[i] = ($urandom_range(0, 3) != 0);
        end else if (!src_vld[i]) begin
          nxt_vld[i] = ($urandom_range(0, 2) == 0);
        end
      end
      cnt_next = cnt + (fifo_write_enable ? 1 : 0);
      if (cnt > 0 && $urandom_range(0, 1) == 1) cnt_next--;
      chk_cnt++;
      if (cnt_next > 8) $display("FAIL rnd_overflow c=%0d occ=%0d max=8", c, cnt_next);
      else pass_cnt++;

      prev_busy  = busy;
      prev_valid = req_valid;
      prev_burst = burst;
      step();
      cnt = cnt_next;
      for (int i = 0; i < N; i++) begin
        src_seq[i] = nxt_seq[i];
        src_vld[i] = nxt_vld[i];
      end
    end
    chk_cnt++;
    if (writes < 500) $display("FAIL rnd_progress got=%0d min=500", writes);
    else pass_cnt++;
    req_valid = '0;
    fifo_full = 1'b0;
  endtask

  initial begin
    write_rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    #1;
    test_reset();
    test_single_burst();
    test_all_valid();
    test_stall();
    test_drop_valid();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter sharing the single write port of the 10-bit CDC FIFO (8-entry, Gray-pointer, write side in `write_clk`) among several QAM symbol sources. Each source offers words through a valid/ready handshake. The arbiter grants one source at a time for a bounded burst, steers its data onto the FIFO write port, and back-pressures it whenever the FIFO reports `full`. It sits entirely in the write clock domain, immediately upstream of the FIFO write-pointer handler.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 10: word width.
- `BURST_MAX`, default 4: maximum beats per grant, 1..15.

Ports:
- `write_clk`, in, 1: sole clock.
- `write_rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: per-requester word valid.
- `req_data`, in, `NUM_REQ*DATA_W`: requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`, out, `NUM_REQ`: per-requester accept.
- `fifo_full`, in, 1: registered full flag from the FIFO write side.
- `fifo_write_enable`, out, 1: FIFO write strobe.
- `fifo_write_data`, out, `DATA_W`: FIFO write word.
- `grant_id`, out, `$clog2(NUM_REQ)`: current owner; valid only while `busy` is high.
- `busy`, out, 1: high in the GRANT state.

## Operation
- Two-state FSM: IDLE and GRANT. Registers: state, `owner`, `last` (round-robin pointer), 4-bit `beats`.
- **IDLE**
  - If any `req_valid` bit is high, select the first valid requester searching from `last+1` upward, wrapping modulo `NUM_REQ`.
  - Register it as `owner`, set `last <= winner`, clear `beats`, go to GRANT.
  - If no request is valid, stay in IDLE.
- **GRANT**
  - `req_ready[owner] = !fifo_full`. All other `req_ready` bits are 0.
  - A beat occurs when `req_valid[owner] & req_ready[owner]`. On a beat: `fifo_write_enable = 1`, `fifo_write_data = req_data[owner]`, and `beats` increments.
  - `fifo_write_enable` and `fifo_write_data` are combinational from the owner mux. `fifo_write_data` is 0 when no beat occurs.
- **Release to IDLE** happens at the next edge when either:
  - a beat occurs with `beats == BURST_MAX-1`, or
  - `req_valid[owner]` is low. This applies even if `fifo_full` is also high.
- Owner valid high with `fifo_full` high: hold the grant. `beats` is unchanged; stall cycles do not consume burst budget.
- Requesters must hold `req_valid` and `req_data` stable until accepted. Dropping valid forfeits the grant.
- Non-owner requests are ignored in GRANT; they remain pending.
- `fifo_write_enable` is never asserted while `fifo_full` is high, so the FIFO's own `write_enable & !full` gating is redundant but harmless.

## Timing
- Reset values: state IDLE, `owner` 0, `last` = `NUM_REQ-1` (so requester 0 wins first), `beats` 0.
- Output values in reset/IDLE: `req_ready` all 0, `fifo_write_enable` 0, `fifo_write_data` 0, `busy` 0, `grant_id` 0.
- Arbitration latency: valid first seen in IDLE at cycle n → GRANT at n+1 → first beat possible at n+1.
- Each release costs one IDLE bubble cycle.
- Full burst throughput: `BURST_MAX` beats in `BURST_MAX+1` cycles.
- `write_rst` asserted mid-burst: the FSM returns to IDLE at that edge. An in-flight beat in that cycle still counts as written by the FIFO if the FIFO is not also reset.
- `fifo_full` rising and falling: `req_ready` follows it in the same cycle, with no registered lag.

## Configuration
- `FIFO_WARB_STATS_EN` defined:
  - Adds output `stat_beats` (`NUM_REQ*16`): per-requester beat counters, saturating at 0xFFFF.
  - Adds output `stat_stall` (16): counts GRANT cycles with owner valid and `fifo_full` high, saturating at 0xFFFF.
  - All counters clear on `write_rst`.
- Not defined: these ports and registers do not exist, and arbitration behaviour is identical.

## Structure
- Package `fifo_warb_pkg`:
  - State enum `{WARB_IDLE, WARB_GRANT}`.
  - `WARB_STAT_W = 16`.
  - Beat counter width `WARB_BEAT_W = 4`.
- Sub-module `rr_pick`: purely combinational round-robin selector.
  - Inputs: `req` vector, `last` pointer.
  - Outputs: `found` and winner index.

## Test plan
- Reset, then pulse only `req_valid[2]` with constant data 0x155 and `BURST_MAX = 4` → grant at cycle 1, four writes of 0x155 on cycles 1–4, IDLE on cycle 5, `grant_id` = 2.
- All four requesters continuously valid → grant order 0,1,2,3,0; each grant has exactly 4 beats with a 1-cycle gap between them.
- Owner 1 granted, `fifo_full` held high for 3 cycles after beat 1 → `req_ready[1]` = 0 and no writes for those cycles, grant retained, then beats 2–4 complete. With the stats macro enabled, `stat_stall` = 3.
- Owner 0 drops valid after 2 beats while requester 3 is valid → IDLE for 1 cycle, then grant 3.
- `write_rst` asserted during beat 2 of a burst → next cycle `busy` = 0 and all `req_ready` = 0; after release, requester 0 wins first.
- Random valid/full traffic against an 8-deep FIFO model → no write while full, no word lost or duplicated, per-source order preserved.
